// File: rtl/pc_sequencer.sv
// Program-counter stage: holds the fetch PC, advances it on retirement by STEP plus
// the branch offset, and emits a one-cycle return-address write on calls.
module pc_sequencer #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              STEP     = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            instr_done,
  input  logic            is_call,
  input  logic            is_halt,
  input  logic [PC_W-1:0] jump_value,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic [PC_W-1:0] ra_wdata,
  output logic            ra_we,
  output logic            halted
);

  localparam logic [PC_W-1:0] STEP_V = PC_W'(STEP);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STALL,
    HALT
  } state_t;

  state_t state;
  state_t state_next;
  logic   advance;

  // Stall takes priority over retirement, and a halting instruction never advances.
  assign advance = (state == RUN) && !stall && instr_done && !is_halt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN: begin
        if (stall) begin
          state_next = STALL;
        end else if (instr_done && is_halt) begin
          state_next = HALT;
        end
      end
      STALL:   if (!stall) state_next = RUN;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pc_valid = (state == RUN);
    halted   = (state == HALT);
  end

  // Return address is captured from the pre-update PC on the same edge the PC moves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      ra_wdata <= '0;
      ra_we    <= 1'b0;
    end else begin
      ra_we <= advance && is_call;
      if (advance) begin
        pc <= pc + STEP_V + jump_value;
        if (is_call) begin
          ra_wdata <= pc + STEP_V;
        end
      end
    end
  end

endmodule
